pe5_psum_drain: RTL
===================

Name: pe5_psum_drain

Overview:
Output-side collector for a 5-tap PE row. It consumes the row's registered partial-sum stream, one sample per valid cycle, and discards the K-1 warm-up positions at the start of every image row. Surviving sums are requantized to signed int8 (round, optional ReLU, saturate) and buffered in a small FIFO behind a valid/ready handshake toward the output buffer writer. It also tracks row and frame position and reports completion and overflow.

Parameters:
BW_IN, 19, signed psum width from the PE row
K, 5, taps per row; first K-1 samples of each image row are discarded
IMG_W, 32, samples per image row (IMG_W >= K)
IMG_H, 32, image rows per frame
SHIFT, 7, requant right shift (0..BW_IN-1)
DEPTH, 4, FIFO entries (power of 2)

Ports:
iCLK  in  1  clock
iRST  in  1  reset, synchronous, active-high
iStart  in  1  frame start pulse; honoured only in IDLE
iRelu  in  1  clamp negatives to 0; sampled at each push
iValid  in  1  iPsum valid this cycle
iPsum  in  BW_IN  signed partial sum from the PE row
oData  out  8  signed int8 result at FIFO head
oValid  out  1  FIFO non-empty
iReady  in  1  consumer accepts oData when oValid && iReady
oBusy  out  1  state != IDLE
oRowDone  out  1  1-cycle pulse, the cycle after the last sample of a row is taken
oFrameDone  out  1  1-cycle pulse, the cycle after DRAIN empties
oOvf  out  1  sticky: a kept sample was dropped because the FIFO was full

Behaviour:
- Reset (iRST=1 at a clock edge), from any state including mid-row or mid-drain:
  - state = IDLE; col = row = 0; FIFO emptied.
  - All outputs 0: oData, oValid, oBusy, oRowDone, oFrameDone, oOvf.
- States:
  - IDLE: iStart -> ACTIVE; clear col, row and oOvf. iValid ignored.
  - ACTIVE: each iValid cycle processes iPsum at the current col, then col++.
    - col < K-1: sample discarded.
    - Otherwise: sample requantized and pushed.
    - At col == IMG_W-1 with iValid: col -> 0; oRowDone pulses next cycle.
      - If row == IMG_H-1: -> DRAIN. Otherwise row++.
    - iStart ignored.
    - Cycles with iValid=0 are bubbles: nothing advances.
  - DRAIN: iValid and iStart ignored. When the FIFO is empty -> IDLE and pulse oFrameDone next cycle.
    - If the FIFO is already empty on entry, the pulse comes one cycle after entry.
- Requant (combinational, before push):
  - s = iPsum + (SHIFT>0 ? 2^(SHIFT-1) : 0), computed in BW_IN+1 bits, no wrap.
  - q = s >>> SHIFT (arithmetic shift).
  - If iRelu and q < 0: q = 0.
  - Saturate q to [-128, 127].
- FIFO:
  - Push and pop are registered. A push at edge t makes oValid=1 from cycle t+1.
  - Pop occurs when oValid && iReady; oData advances to the next entry the following cycle.
  - Full with simultaneous pop and push: both succeed, occupancy unchanged.
  - Full, push, no pop: sample dropped, oOvf set; existing contents unchanged.
  - Empty with push: no same-cycle bypass.
  - oData holds its last value when oValid=0.
- Ordering: output order equals input order. No sample is ever duplicated.

Test Plan:
1. Requant, SHIFT=4, 1-entry checks:
   - iPsum 100 -> 6; -100 -> -6; -100 with iRelu -> 0.
   - 5000 -> 127; -5000 -> -128; 7 -> 0; 8 -> 1.
2. Warm-up discard, IMG_W=8, IMG_H=2, SHIFT=4, iReady=1: iStart, then 8 consecutive valids with iPsum = 16*k, k=0..7.
   -> Outputs exactly 4, 5, 6, 7 in order.
   -> oRowDone high for exactly one cycle, the cycle after k=7.
3. Backpressure, same configuration, iReady=0:
   - Row 0 fills the FIFO (4 entries), oOvf=0.
   - First kept sample of row 1 -> oOvf=1.
   - Then iReady=1 -> pops 4, 5, 6, 7 only.
4. Frame end: both rows streamed with iReady=1.
   -> State enters DRAIN after the 16th valid.
   -> oFrameDone pulses once after the last pop; oBusy falls the same cycle.
   -> Further iValid produces nothing.
5. Bubbles: the row-0 stream of test 2 with iValid toggling 1,0,1,0...
   -> Identical output values and order; oRowDone follows the 8th valid.
6. Reset mid-row: iRST asserted after the 2nd kept push.
   -> Next cycle: oValid=0, oBusy=0, oOvf=0.
   -> Subsequent iValid ignored until iStart; a fresh row again discards its first 4 samples.

Source files
------------

// File: rtl/pe5_psum_drain.sv
// Output collector for a 5-tap PE row: drops per-row warm-up sums, requantizes
// survivors to int8 and queues them behind a valid/ready port; tracks row/frame.
module pe5_psum_drain #(
  parameter int BW_IN = 19,
  parameter int K     = 5,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int SHIFT = 7,
  parameter int DEPTH = 4
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iStart,
  input  logic                    iRelu,
  input  logic                    iValid,
  input  logic signed [BW_IN-1:0] iPsum,
  output logic signed [7:0]       oData,
  output logic                    oValid,
  input  logic                    iReady,
  output logic                    oBusy,
  output logic                    oRowDone,
  output logic                    oFrameDone,
  output logic                    oOvf
);
  localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RND_I  = (2 ** SHIFT) / 2;
  localparam logic signed [BW_IN:0] RND    = (BW_IN+1)'(RND_I);
  localparam logic signed [BW_IN:0] SAT_HI = (BW_IN+1)'(127);
  localparam logic signed [BW_IN:0] SAT_LO = -(BW_IN+1)'(128);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic                   ovf_q, ovf_d;
  logic                   row_done_q, row_done_d;
  logic                   frame_done_q, frame_done_d;
  logic [DEPTH-1:0][7:0]  mem_q, mem_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            cnt_q, cnt_d;
  logic [7:0]             last_q, last_d;

  logic                   keep, push, pop, full;
  logic signed [BW_IN:0]  s_w, q_w;
  logic signed [7:0]      rq;

  // Rounding add is one bit wider than the input so it can never wrap.
  always_comb begin
    s_w = $signed({iPsum[BW_IN-1], iPsum}) + RND;
    q_w = s_w >>> SHIFT;
    if (iRelu && q_w < 0) q_w = '0;
    if (q_w > SAT_HI)      rq = 8'sd127;
    else if (q_w < SAT_LO) rq = -8'sd128;
    else                   rq = q_w[7:0];
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    ovf_d        = ovf_q;
    row_done_d   = 1'b0;
    frame_done_d = 1'b0;
    keep         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = S_ACTIVE;
          col_d   = '0;
          row_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (iValid) begin
          keep = (col_q >= CW'(K-1));
          if (col_q == CW'(IMG_W-1)) begin
            col_d      = '0;
            row_done_d = 1'b1;
            if (row_q == RW'(IMG_H-1)) state_d = S_DRAIN;
            else                       row_d   = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop frees the slot on the same edge, so full+pop+push still succeeds.
    full     = (cnt_q == (AW+1)'(DEPTH));
    pop      = (cnt_q != '0) && iReady;
    push     = keep && (!full || pop);
    if (keep && full && !pop) ovf_d = 1'b1;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    if (push) begin
      mem_d[wr_ptr_q] = rq;
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      ovf_q        <= 1'b0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      mem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      last_q       <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      ovf_q        <= ovf_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
    end
  end

  // Head of queue when non-empty, otherwise the most recently popped value.
  assign oData      = (cnt_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign oValid     = (cnt_q != '0);
  assign oBusy      = (state_q != S_IDLE);
  assign oRowDone   = row_done_q;
  assign oFrameDone = frame_done_q;
  assign oOvf       = ovf_q;
endmodule
